// File: rtl/sisc_core_p.sv
// sisc_core_p: parametrised multicycle SISC core.
//   Instructions are fetched over a req/ack handshake, then decoded, executed
//   and (for ALU ops) written back. The core has immediate ALU ops,
//   conditional absolute and relative branches, halt, and a debug register
//   read port.
// Ports:
//   clk, rst_f       clock (rising edge), asynchronous active-low reset
//   imem_addr/req    fetch address (= pc) and request (high only in FETCH)
//   imem_ack/rdata   instruction valid / word, sampled when req & ack
//   pc, stat         program counter, status {C,N,V,Z}
//   halted           high in HALT
//   dbg_sel/data     combinational register read (0 for index >= NREG)
module sisc_core_p #(
    parameter int DW   = 32,
    parameter int NREG = 16,
    parameter int PCW  = 16
) (
    input  logic           clk,
    input  logic           rst_f,
    output logic [PCW-1:0] imem_addr,
    output logic           imem_req,
    input  logic           imem_ack,
    input  logic [31:0]    imem_rdata,
    output logic [PCW-1:0] pc,
    output logic [3:0]     stat,
    output logic           halted,
    input  logic [3:0]     dbg_sel,
    output logic [DW-1:0]  dbg_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
    } state_t;

    state_t        state, state_nxt;
    logic [31:0]   ir;
    logic [DW-1:0] regs [NREG];
    logic [DW-1:0] opa, opb, res_q;
    logic [3:0]    flags_q;

    logic [3:0]    op, mm, rd, rs, rt;
    logic [15:0]   imm;
    logic [DW-1:0] imm_dw;

    assign op  = ir[31:28];
    assign mm  = ir[27:24];
    assign rd  = ir[23:20];
    assign rs  = ir[19:16];
    assign rt  = ir[15:12];
    assign imm = ir[15:0];
    // Size cast of a signed value sign-extends (DW > 16) or truncates (DW < 16).
    assign imm_dw = DW'($signed(imm));

    // Register read; indices with no backing register return zero.
    function automatic logic [DW-1:0] rd_reg(input logic [3:0] idx);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < NREG; i++)
            if (idx == 4'(i)) r = regs[i];
        return r;
    endfunction

    always_comb dbg_data = rd_reg(dbg_sel);

    // ALU on the operands latched in DECODE.
    logic [DW:0]   sum, dif;
    logic [DW-1:0] alu_res;
    logic          alu_c, alu_v;

    always_comb begin
        sum     = {1'b0, opa} + {1'b0, opb};
        dif     = {1'b0, opa} - {1'b0, opb};
        alu_res = sum[DW-1:0];
        alu_c   = sum[DW];
        alu_v   = (opa[DW-1] == opb[DW-1]) && (sum[DW-1] != opa[DW-1]);
        case (mm)
            4'd1: begin
                alu_res = dif[DW-1:0];
                alu_c   = dif[DW];  // borrow: set when opa < opb unsigned
                alu_v   = (opa[DW-1] != opb[DW-1]) && (dif[DW-1] != opa[DW-1]);
            end
            4'd2: begin alu_res = opa & opb; alu_c = 1'b0; alu_v = 1'b0; end
            4'd3: begin alu_res = opa | opb; alu_c = 1'b0; alu_v = 1'b0; end
            4'd4: begin alu_res = opa ^ opb; alu_c = 1'b0; alu_v = 1'b0; end
            4'd5: begin alu_res = ~opa;      alu_c = 1'b0; alu_v = 1'b0; end
            default: ;
        endcase
    end

    // Branch condition and targets.
    logic           take;
    logic [PCW-1:0] pc_inc, bra_tgt, brr_tgt;

    assign take    = (mm == 4'd0) || ((stat & mm) != 4'd0);
    assign pc_inc  = pc + PCW'(1);
    assign bra_tgt = PCW'(imm);
    assign brr_tgt = pc_inc + PCW'($signed(imm));

    // State register
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   state_nxt = S_FETCH;
            S_FETCH:  if (imem_ack) state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC: begin
                if (op == 4'h1 || op == 4'h2) state_nxt = S_WB;
                else if (op == 4'hF)          state_nxt = S_HALT;
                else                          state_nxt = S_FETCH;
            end
            S_WB:     state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        imem_req  = (state == S_FETCH);
        halted    = (state == S_HALT);
        imem_addr = pc;
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            pc      <= '0;
            ir      <= '0;
            stat    <= '0;
            opa     <= '0;
            opb     <= '0;
            res_q   <= '0;
            flags_q <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: if (imem_ack) ir <= imem_rdata;
                S_DECODE: begin
                    opa <= rd_reg(rs);
                    opb <= (op == 4'h2) ? imm_dw : rd_reg(rt);
                end
                S_EXEC: begin
                    case (op)
                        4'h1, 4'h2: begin
                            res_q   <= alu_res;
                            flags_q <= {alu_c, alu_res[DW-1], alu_v, alu_res == '0};
                        end
                        4'h4:    pc <= take ? bra_tgt : pc_inc;
                        4'h5:    pc <= take ? brr_tgt : pc_inc;
                        4'hF:    ;  // halt keeps pc pointing at the HLT
                        default: pc <= pc_inc;
                    endcase
                end
                S_WB: begin
                    // rd beyond NREG matches no register, so the write drops.
                    for (int i = 0; i < NREG; i++)
                        if (rd == 4'(i)) regs[i] <= res_q;
                    stat <= flags_q;
                    pc   <= pc_inc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sisc_core_p.sv
// tb_sisc_core_p: randomized scoreboard bench for sisc_core_p.
//   An instruction-memory responder feeds words from a program queue with
//   chosen wait states; each accepted word is run through an ISA-level model
//   and the expected architectural state is queued. A monitor pops one entry
//   each time the core starts a new fetch (or halts) and compares. A second,
//   narrow instance (DW=8, NREG=4, PCW=8) gets a few directed instructions.
module tb_sisc_core_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance, default parameters
    logic        rst_f;
    logic [15:0] imem_addr, pc;
    logic        imem_req, imem_ack, halted;
    logic [31:0] imem_rdata, dbg_data;
    logic [3:0]  stat, dbg_sel;

    sisc_core_p #(.DW(32), .NREG(16), .PCW(16)) dut (
        .clk(clk), .rst_f(rst_f), .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc), .stat(stat),
        .halted(halted), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    // Narrow instance
    logic        rst8, req8, ack8, halt8;
    logic [7:0]  addr8, pc8, dbg8;
    logic [31:0] rdata8;
    logic [3:0]  stat8, sel8;

    sisc_core_p #(.DW(8), .NREG(4), .PCW(8)) dut8 (
        .clk(clk), .rst_f(rst8), .imem_addr(addr8), .imem_req(req8),
        .imem_ack(ack8), .imem_rdata(rdata8), .pc(pc8), .stat(stat8),
        .halted(halt8), .dbg_sel(sel8), .dbg_data(dbg8)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ISA-level reference model
    typedef struct { logic [15:0] pc; logic [3:0] stat; int lat; logic [3:0] ri; logic [31:0] rv; } exp_t;
    typedef struct { logic [31:0] ins; int waits; } prog_t;

    exp_t        sb[$];
    prog_t       prog[$];
    logic [31:0] mregs [16];
    logic [15:0] mpc;
    logic [3:0]  mstat;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mregs[i] = '0;
        mpc = '0;
        mstat = '0;
        sb.delete();
        prog.delete();
    endtask

    task automatic model_exec(input logic [31:0] ins, input int waits, input bit late);
        logic [3:0] op, mm, rd, rs, rt;
        logic [31:0] a, b, r;
        longint unsigned ua, ub, ur;
        longint sa, sbv, sr;
        logic c, v;
        exp_t e;
        op = ins[31:28]; mm = ins[27:24]; rd = ins[23:20]; rs = ins[19:16]; rt = ins[15:12];
        a = mregs[rs];
        b = (op == 4'h1) ? mregs[rt] : {{16{ins[15]}}, ins[15:0]};
        e.lat = waits + 3;
        e.ri  = 4'($urandom_range(0, 15));
        case (op)
            4'h1, 4'h2: begin
                ua = 64'(a); ub = 64'(b);
                sa = longint'($signed(a)); sbv = longint'($signed(b));
                c = 1'b0; v = 1'b0; sr = 0;
                case (mm)
                    4'd1: begin ur = ua - ub; sr = sa - sbv; c = (ua < ub); end
                    4'd2: ur = ua & ub;
                    4'd3: ur = ua | ub;
                    4'd4: ur = ua ^ ub;
                    4'd5: ur = ~ua;
                    default: begin ur = ua + ub; sr = sa + sbv; c = ur[32]; end
                endcase
                if (mm == 4'd1 || mm == 4'd0 || mm > 4'd5)
                    v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
                r = ur[31:0];
                mregs[rd] = r;
                mstat = {c, r[31], v, r == 32'd0};
                mpc = mpc + 16'd1;
                e.lat = waits + 4;
                e.ri = rd;
            end
            4'h4, 4'h5: begin
                if (mm == 4'd0 || (mstat & mm) != 4'd0)
                    mpc = (op == 4'h4) ? ins[15:0] : mpc + 16'd1 + ins[15:0];
                else
                    mpc = mpc + 16'd1;
            end
            4'hF: ;
            default: mpc = mpc + 16'd1;
        endcase
        if (late) e.lat = -1;
        e.pc = mpc;
        e.stat = mstat;
        e.rv = mregs[e.ri];
        sb.push_back(e);
    endtask

    function automatic logic [31:0] rand_ins();
        logic [3:0] op;
        case ($urandom_range(0, 9))
            0:       op = 4'h0;
            1, 2, 3: op = 4'h1;
            4, 5, 6: op = 4'h2;
            7:       op = 4'h4;
            8:       op = 4'h5;
            default: op = 4'($urandom_range(6, 14));
        endcase
        return {op, 4'($urandom), 4'($urandom), 4'($urandom), 16'($urandom)};
    endfunction

    task automatic push(input logic [31:0] ins, input int waits);
        prog_t p;
        p.ins = ins;
        p.waits = waits;
        prog.push_back(p);
    endtask

    // Instruction memory responder
    initial begin
        int wcnt;
        bit late;
        prog_t p;
        wcnt = -1;
        late = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = '0;
        forever begin
            @(negedge clk);
            imem_ack = 1'b0;
            imem_rdata = $urandom;
            if (!rst_f) begin wcnt = -1; late = 1'b0; continue; end
            if (!imem_req) begin
                // Stray acks outside FETCH must be ignored by the core.
                wcnt = -1; late = 1'b0;
                imem_ack = ($urandom_range(0, 3) == 0);
                continue;
            end
            if (wcnt < 0) begin
                if (prog.size() == 0) begin late = 1'b1; continue; end
                wcnt = prog[0].waits;
            end
            if (wcnt > 0) wcnt--;
            else begin
                p = prog.pop_front();
                chk("fetch_addr", 32'(imem_addr), 32'(mpc));
                imem_ack = 1'b1;
                imem_rdata = p.ins;
                model_exec(p.ins, p.waits, late);
                wcnt = -1;
                late = 1'b0;
            end
        end
    end

    // Retirement monitor
    initial begin
        bit pr, ph;
        int cyc;
        exp_t e;
        pr = 1'b0; ph = 1'b0; cyc = 0;
        dbg_sel = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_f) begin pr = 1'b0; ph = 1'b0; cyc = 0; continue; end
            cyc++;
            if ((imem_req && !pr) || (halted && !ph)) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("pc", 32'(pc), 32'(e.pc));
                    chk("stat", 32'(stat), 32'(e.stat));
                    if (e.lat >= 0) chk("latency", cyc, e.lat);
                    dbg_sel = e.ri;
                    #1;
                    chk("reg", dbg_data, e.rv);
                end
                cyc = 0;
            end
            pr = imem_req;
            ph = halted;
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while ((prog.size() != 0 || sb.size() != 0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) begin
            checks++; errors++;
            $display("FAIL drain_timeout: prog=%0d sb=%0d", prog.size(), sb.size());
        end
    endtask

    task automatic release_check();
        @(negedge clk);
        rst_f = 1'b1;
        #1 chk("req_at_release", 32'(imem_req), 32'd0);
        @(negedge clk);
        #1 chk("req_one_cycle_after", 32'(imem_req), 32'd1);
        chk("addr_first", 32'(imem_addr), 32'd0);
    endtask

    task automatic run8(input logic [31:0] ins);
        int n;
        n = 0;
        while (!req8 && n < 50) begin @(negedge clk); n++; end
        if (!req8) begin
            checks++; errors++;
            $display("FAIL n8_req_timeout: got 0 expected 1");
            return;
        end
        ack8 = 1'b1;
        rdata8 = ins;
        @(negedge clk);
        ack8 = 1'b0;
        n = 0;
        while (!req8 && n < 50) begin @(negedge clk); n++; end
        if (!req8) begin
            checks++; errors++;
            $display("FAIL n8_retire_timeout: got 0 expected 1");
        end
    endtask

    initial begin
        logic [15:0] hpc;
        rst_f = 1'b0;
        rst8 = 1'b0; ack8 = 1'b0; rdata8 = '0; sel8 = '0;
        model_reset();
        repeat (3) @(negedge clk);

        // Directed program: loaded before release so latency is measured
        // from the very first request.
        push(32'h2010_0005, 3);               // R1 = 5, 3 wait states
        push(32'h2010_0001, 0);               // R1 = 1
        for (int i = 0; i < 31; i++) push(32'h1011_1000, $urandom_range(0, 1)); // R1 += R1
        push(32'h2111_0001, 0);               // R1 = 0x7FFFFFFF
        push(32'h2011_0001, 0);               // R1 = 0x80000000, N V
        push(32'h1121_1000, 0);               // R2 = R1 - R1, Z
        push(32'h4100_0040, 0);               // BRA on Z taken -> 0x40
        push(32'h2030_0001, 0);               // clears Z
        push(32'h4100_0040, 0);               // not taken -> pc+1
        push(32'h4000_0010, 0);               // pc = 0x10
        push(32'h5000_FFFE, 1);               // BRR -2 -> 0x000F
        push(32'h4000_FFFF, 0);               // pc = 0xFFFF
        push(32'h0000_0000, 0);               // NOP wraps pc to 0
        release_check();
        drain();

        // Random traffic
        for (int i = 0; i < 250; i++) push(rand_ins(), $urandom_range(0, 3));
        drain();

        // Reset while a fetch is outstanding
        @(negedge clk);
        #2 chk("req_before_reset", 32'(imem_req), 32'd1);
        #1 rst_f = 1'b0;
        model_reset();
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_stat", 32'(stat), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        for (int i = 0; i < 16; i++) begin
            dbg_sel = 4'(i);
            #1 chk("rst_reg", dbg_data, 32'd0);
        end
        for (int i = 0; i < 60; i++) push(rand_ins(), $urandom_range(0, 2));
        push(32'hF000_0000, 1);
        release_check();
        drain();

        // Halt is absorbing
        hpc = mpc;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #3;
            chk("halt_halted", 32'(halted), 32'd1);
            chk("halt_req", 32'(imem_req), 32'd0);
            chk("halt_pc", 32'(pc), 32'(hpc));
        end
        @(negedge clk);
        #3 rst_f = 1'b0;
        model_reset();
        #1 chk("halt_exit", 32'(halted), 32'd0);
        release_check();

        // Narrow instance: DW=8, NREG=4, PCW=8
        @(negedge clk);
        rst8 = 1'b1;
        run8(32'h2010_007F);                  // R1 = 0x7F
        sel8 = 4'd1;
        #1 chk("n8_r1_7f", 32'(dbg8), 32'h7F);
        run8(32'h2011_0001);                  // R1 = 0x80, N and V
        #1 chk("n8_r1_80", 32'(dbg8), 32'h80);
        chk("n8_stat", 32'(stat8), 32'b0110);
        run8(32'h2050_0003);                  // R5 does not exist
        sel8 = 4'd5;
        #1 chk("n8_r5", 32'(dbg8), 32'd0);
        chk("n8_pc", 32'(pc8), 32'd3);
        run8(32'h4000_1234);                  // BRA truncates target
        #1 chk("n8_bra", 32'(pc8), 32'h34);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
